// File: rtl/disp_pkg.sv
// Shared seven-segment types, constants and the BCD-to-segment mapping.
// Segment bits are logical, active-high, in {g,f,e,d,c,b,a} order.
package disp_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t      SEG_BLANK   = 7'h00;
  localparam seg7_t      SEG_DASH    = 7'h40;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // Codes 10-14 show a dash so an upstream error stays visible on the display.
  function automatic seg7_t bcd_to_seg7(input logic [3:0] digit);
    seg7_t segs;
    case (digit)
      4'd0:        segs = 7'h3F;
      4'd1:        segs = 7'h06;
      4'd2:        segs = 7'h5B;
      4'd3:        segs = 7'h4F;
      4'd4:        segs = 7'h66;
      4'd5:        segs = 7'h6D;
      4'd6:        segs = 7'h7D;
      4'd7:        segs = 7'h07;
      4'd8:        segs = 7'h7F;
      4'd9:        segs = 7'h6F;
      DIGIT_BLANK: segs = SEG_BLANK;
      default:     segs = SEG_DASH;
    endcase
    return segs;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decoder (logical, active-high segments).
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] digit_i,
  output seg7_t      seg_o
);

  assign seg_o = bcd_to_seg7(digit_i);

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed 4-digit seven-segment scanner with per-frame digit snapshot,
// leading-zero suppression and a blank guard window at the start of each slot.
module display_scan
  import disp_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int GUARD          = 1,
  parameter int LZ_SUPPRESS    = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int             CW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  GUARD_CNT = CW'(GUARD);
  localparam seg7_t          SEG_MASK  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [3:0]     AN_MASK   = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][3:0] shadow_q, shadow_d;
  seg7_t           seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            frameDone_q, frameDone_d;

  logic            tick;
  logic            frameStart;
  logic [3:0][3:0] lzDigits;
  seg7_t           segLogic;

  assign tick       = (cnt_q == CNT_MAX);
  assign frameStart = enable && (cnt_q == '0) && (idx_q == 2'd0);

  // A zero is only suppressed when every more significant digit is already blank.
  always_comb begin
    lzDigits = {d3, d2, d1, d0};
    if (LZ_SUPPRESS != 0) begin
      if (d3 == 4'd0)                              lzDigits[3] = DIGIT_BLANK;
      if (d2 == 4'd0 && lzDigits[3] == DIGIT_BLANK) lzDigits[2] = DIGIT_BLANK;
      if (d1 == 4'd0 && lzDigits[2] == DIGIT_BLANK) lzDigits[1] = DIGIT_BLANK;
    end
  end

  seg7_decode u_decode (
    .digit_i (shadow_q[idx_q]),
    .seg_o   (segLogic)
  );

  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick)       idx_d    = idx_q + 2'd1;
      if (frameStart) shadow_d = lzDigits;
    end
  end

  // The guard window keeps all anodes off while the previous digit's segments settle.
  always_comb begin
    seg_d       = SEG_BLANK ^ SEG_MASK;
    an_d        = AN_MASK;
    frameDone_d = enable && tick && (idx_q == 2'd3);
    if (enable && cnt_q >= GUARD_CNT) begin
      seg_d = segLogic ^ SEG_MASK;
      an_d  = (4'b0001 << idx_q) ^ AN_MASK;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      shadow_q    <= {4{DIGIT_BLANK}};
      seg_q       <= SEG_BLANK ^ SEG_MASK;
      an_q        <= AN_MASK;
      frameDone_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frameDone_q;

endmodule

// File: doc/display_scan.md
Name: display_scan

Overview:
- Time-multiplexed 4-digit seven-segment driver directly downstream of the binary-to-BCD digit splitter.
- Consumes its four BCD digits d0..d3. Digit code 4'hF means blank, which is what the splitter emits when disabled.
- Snapshots the digits once per frame and scans one anode at a time.
- Decodes to segments with optional leading-zero suppression and an inter-digit guard blank to prevent ghosting.

Parameters:
- CLK_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- GUARD, 1: blanked cycles at the start of each slot; 1 ≤ GUARD < CLK_DIV.
- LZ_SUPPRESS, 1: 1 = blank leading zeros in d3..d1.
- SEG_ACTIVE_LOW, 1: 1 = seg pins driven inverted.
- AN_ACTIVE_LOW, 1: 1 = anode pins driven inverted.

Ports:
- clock  in  1  system clock, single clock domain.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  1 = scan runs; 0 = display dark, state frozen.
- d0  in  4  units digit (BCD; 4'hF = blank).
- d1  in  4  tens digit.
- d2  in  4  hundreds digit.
- d3  in  4  thousands digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- an  out  4  anode selects, an[i] drives digit i, polarity per AN_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse at the last cycle of slot 3.

Behaviour:
- Reset: one clock, synchronous active-low (reset_n=0 sampled on a clock edge).
  - Prescaler cnt=0, slot index idx=0.
  - Shadow digits = 4'hF ×4.
  - seg = all segments off, an = all anodes off (physical levels per polarity parameters).
  - frame_done = 0.
- Reset asserted mid-frame aborts the frame; the next frame restarts at idx=0, cnt=0.
- Prescaler:
  - When enable=1, cnt counts 0..CLK_DIV-1 and wraps.
  - tick = (cnt == CLK_DIV-1).
  - On tick, idx advances 0→1→2→3→0.
- Frame start = enable && cnt==0 && idx==0. This includes the first enabled cycle after reset.
- Snapshot at frame start:
  - Shadow loads d0..d3, with leading-zero suppression applied.
  - Inputs are not sampled at any other time, so changes mid-frame are invisible until the next frame.
- Leading-zero suppression (LZ_SUPPRESS=1):
  - d3==0 → blank.
  - d2==0 → blank if d3 is blank or 0.
  - d1==0 → blank if d2 was blanked (or is 4'hF).
  - d0 is never suppressed.
  - With LZ_SUPPRESS=0, digits pass unchanged.
- Output register (1-cycle latency):
  - seg/an are registered from the current cycle's cnt, idx and shadow.
  - Since the frame-start cycle is a guard cycle, the freshly loaded shadow is first visible at cnt==GUARD.
- Guard blanking:
  - When cnt < GUARD in the sampled cycle, the registered outputs are all anodes off and seg blank.
  - Otherwise only anode idx is on, and seg = decode(shadow[idx]).
- Decode (logical, active-high segment bits):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - 10–14: 40 (dash = error indicator).
  - 15: 00 (blank).
  - Physical seg = logical ^ {7{SEG_ACTIVE_LOW}}.
- frame_done:
  - Registered.
  - Asserts for exactly one cycle following the cycle with tick && idx==3 && enable.
  - With enable held high, period = 4·CLK_DIV cycles.
- enable=0:
  - cnt, idx and shadow hold.
  - Next cycle outputs go dark (all anodes off).
  - No frame_done pulse.
  - Re-enabling resumes from the held cnt/idx. A snapshot occurs only if the resumed state is cnt==0 && idx==0.
- Widths:
  - cnt is $clog2(CLK_DIV) bits.
  - idx is 2 bits; its wrap from 3 to 0 comes from natural overflow.

Decomposition:
- Shared package disp_pkg:
  - seg7_t (7-bit) typedef.
  - SEG_BLANK, SEG_DASH, DIGIT_BLANK=4'hF constants.
  - Pure function bcd_to_seg7.
- One natural sub-module: seg7_decode, the combinational decoder wrapping bcd_to_seg7, reusable elsewhere.
- Prescaler, scan index, snapshot and output registers stay in display_scan.

Test Plan:
(Sim config: CLK_DIV=4, GUARD=1, both polarities active-low.)
1. Reset: hold reset_n=0 for 3 cycles with enable=1, d=1,2,3,4 → seg=7'h7F, an=4'hF, frame_done=0 throughout; the first lit anode appears 2 cycles after release.
2. Scan order: d3..d0=1,2,3,4, LZ_SUPPRESS=0 → per 4-cycle slot, 1 dark cycle then 3 cycles of each pair in turn: an=1110/seg=~66, an=1101/seg=~4F, an=1011/seg=~5B, an=0111/seg=~06; frame_done pulses every 16 cycles.
3. Leading zeros: d3..d0=0,0,0,7 → slots 1–3 seg=7'h7F (blank), slot 0 seg=~07; with d=0,0,0,0 → only slot 0 shows ~3F; with d=0,5,0,0 → slot 3 blank, slots 2, 1, 0 show 5, 0, 0.
4. Snapshot: d=1,2,3,4, then change to 9,9,9,9 during slot 1 → the current frame still shows 1,2,3,4; 9s appear starting in the frame after the next frame start.
5. Special codes: d0=4'hF, d1=4'hA → slot 0 blank (7'h7F), slot 1 dash (~40 = 7'h3F).
6. Control: drop enable mid-slot 2 for 10 cycles → an=4'hF one cycle later, no frame_done, resumes slot 2 at the held cnt; assert reset_n=0 mid-slot 3 → outputs dark and the next frame restarts at slot 0 with a new snapshot.
